// File: rtl/qoi_rgb444_pkg.sv
// Shared types and constants for the RGB444 QOI-style encoder.
// Op tags, run limit, pixel type, FSM state encoding and the DIFF helper.
package qoi_rgb444_pkg;

    localparam logic [1:0] OP_INDEX = 2'b00;
    localparam logic [1:0] OP_DIFF  = 2'b01;
    localparam logic [1:0] OP_RAW   = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    localparam int unsigned RUN_MAX  = 63;
    localparam int unsigned PAL_SIZE = 64;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [2:0] {
        S_IN,
        S_RUNOP,
        S_OP,
        S_RAW2,
        S_PAD
    } state_e;

    // Returns {legal, dr[1:0], dg[1:0], db[1:0]} with d = (prev - cur + 2) mod 16.
    function automatic logic [6:0] diff_op(rgb444_t prev, rgb444_t cur);
        logic [3:0] dr;
        logic [3:0] dg;
        logic [3:0] db;
        dr = prev[11:8] - cur[11:8] + 4'd2;
        dg = prev[7:4] - cur[7:4] + 4'd2;
        db = prev[3:0] - cur[3:0] + 4'd2;
        return {(dr[3:2] == 2'b00) && (dg[3:2] == 2'b00) && (db[3:2] == 2'b00),
                dr[1:0], dg[1:0], db[1:0]};
    endfunction

endpackage

// File: rtl/qoi_rgb444_encoder_if.sv
// Pixel-in / byte-out stream bundle of the RGB444 encoder.
// master is the encoder's view, slave is the surrounding pipeline's view.
interface qoi_rgb444_encoder_if;
    import qoi_rgb444_pkg::*;

    logic       pix_valid;
    logic       pix_ready;
    rgb444_t    pix_rgb;
    logic       pix_first;
    logic       pix_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport master (
        input  pix_valid, pix_rgb, pix_first, pix_last, out_ready,
        output pix_ready, out_valid, out_byte, out_last
    );

    modport slave (
        output pix_valid, pix_rgb, pix_first, pix_last, out_ready,
        input  pix_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/qoi_rgb444_palette_match.sv
// Combinational 64-entry palette lookup: hit flag plus the lowest matching index.
module qoi_rgb444_palette_match
    import qoi_rgb444_pkg::*;
(
    input  rgb444_t                pix_i,
    input  rgb444_t [PAL_SIZE-1:0] palette_i,
    output logic                   hit_o,
    output logic [5:0]             idx_o
);

    // Scan from the top so the lowest matching entry is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        idx_o = 6'd0;
        for (int i = PAL_SIZE - 1; i >= 0; i--) begin
            if (palette_i[i] == pix_i) begin
                hit_o = 1'b1;
                idx_o = 6'(i);
            end
        end
    end

endmodule

// File: rtl/qoi_rgb444_encoder.sv
// Streaming RGB444 encoder emitting INDEX/DIFF/RAW/RUN ops in fixed CHUNK_BYTES chunks.
// Define QOI_ENC_INDEX_EN to build the palette compare and emit INDEX ops.
module qoi_rgb444_encoder
    import qoi_rgb444_pkg::*;
#(
    parameter int unsigned CHUNK_BYTES = 320,
    parameter logic [7:0]  PAD_BYTE    = 8'hC1
) (
    input  logic                   clk,
    input  logic                   rst,
    qoi_rgb444_encoder_if.master   io,
    input  rgb444_t [PAL_SIZE-1:0] palette,
    output logic                   overflow
);

    localparam int unsigned        CntW   = $clog2(CHUNK_BYTES + 3);
    localparam logic [CntW-1:0]    ChunkC = CntW'(CHUNK_BYTES);

    state_e          state_q, state_d;
    logic            pix_ready_q, pix_ready_d;
    rgb444_t         prev_q, prev_d;
    logic [5:0]      run_q, run_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      run_byte_q, run_byte_d;
    logic [7:0]      op_b0_q, op_b0_d;
    logic [7:0]      op_b1_q, op_b1_d;
    logic            op_raw_q, op_raw_d;
    logic            op_has_q, op_has_d;
    logic            last_q, last_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            out_last_q, out_last_d;

    logic            pal_hit;
    logic [5:0]      pal_idx;

`ifdef QOI_ENC_INDEX_EN
    qoi_rgb444_palette_match u_match (
        .pix_i     (io.pix_rgb),
        .palette_i (palette),
        .hit_o     (pal_hit),
        .idx_o     (pal_idx)
    );
`else
    logic unused_palette;
    assign unused_palette = ^palette;
    assign pal_hit        = 1'b0;
    assign pal_idx        = 6'd0;
`endif

    logic            accept, first, eq, n_run_em, n_has_op, n_raw, free, load;
    rgb444_t         prev_eff;
    logic [5:0]      run_eff, run_inc, n_run;
    logic [CntW-1:0] cnt_eff, cnt_p1, cnt_p2;
    logic            ovf_eff;
    logic [6:0]      diff;
    logic [7:0]      n_run_b, n_b0, load_byte;
    state_e          entry, cs, tail;

    always_comb begin
        accept   = io.pix_valid && pix_ready_q;
        first    = accept && io.pix_first;
        prev_eff = first ? rgb444_t'(0) : prev_q;
        run_eff  = first ? 6'd0 : run_q;
        cnt_eff  = first ? '0 : cnt_q;
        ovf_eff  = first ? 1'b0 : ovf_q;
        cnt_p1   = cnt_eff + CntW'(1);
        cnt_p2   = cnt_eff + CntW'(2);

        // Ops generated by the pixel being offered this cycle.
        eq       = (io.pix_rgb == prev_eff);
        run_inc  = run_eff + 6'd1;
        diff     = diff_op(prev_eff, io.pix_rgb);
        n_run_em = 1'b0;
        n_run_b  = {OP_RUN, run_eff};
        n_has_op = 1'b0;
        n_run    = 6'd0;
        if (eq) begin
            if ((run_inc == 6'(RUN_MAX)) || io.pix_last) begin
                n_run_em = 1'b1;
                n_run_b  = {OP_RUN, run_inc};
            end else begin
                n_run = run_inc;
            end
        end else begin
            n_run_em = (run_eff != 6'd0);
            n_has_op = 1'b1;
        end
        n_raw = 1'b0;
        if (pal_hit) begin
            n_b0 = {OP_INDEX, pal_idx};
        end else if (diff[6]) begin
            n_b0 = {OP_DIFF, diff[5:0]};
        end else begin
            n_b0  = {OP_RAW, 2'b00, io.pix_rgb[11:8]};
            n_raw = 1'b1;
        end

        run_byte_d = accept ? n_run_b : run_byte_q;
        op_b0_d    = accept ? n_b0 : op_b0_q;
        op_b1_d    = accept ? io.pix_rgb[7:0] : op_b1_q;
        op_raw_d   = accept ? n_raw : op_raw_q;
        op_has_d   = accept ? n_has_op : op_has_q;
        last_d     = accept ? io.pix_last : last_q;
        prev_d     = accept ? io.pix_rgb : prev_q;
        run_d      = accept ? n_run : run_q;

        tail  = last_d ? S_PAD : S_IN;
        entry = n_run_em ? S_RUNOP : (n_has_op ? S_OP : (io.pix_last ? S_PAD : S_IN));
        // A freshly accepted pixel is emitted in the same cycle it enters.
        cs    = accept ? entry : state_q;

        free      = !out_valid_q || io.out_ready;
        load      = 1'b0;
        load_byte = 8'h00;
        state_d   = cs;
        cnt_d     = cnt_eff;
        ovf_d     = ovf_eff;
        unique case (cs)
            S_IN: ;
            S_RUNOP: begin
                if (cnt_p1 > ChunkC) begin
                    ovf_d   = 1'b1;
                    state_d = op_has_d ? S_OP : tail;
                end else if (free) begin
                    load      = 1'b1;
                    load_byte = run_byte_d;
                    state_d   = op_has_d ? S_OP : tail;
                end
            end
            S_OP: begin
                // A RAW pair either fits whole or is dropped whole.
                if (op_raw_d ? (cnt_p2 > ChunkC) : (cnt_p1 > ChunkC)) begin
                    ovf_d   = 1'b1;
                    state_d = tail;
                end else if (free) begin
                    load      = 1'b1;
                    load_byte = op_b0_d;
                    state_d   = op_raw_d ? S_RAW2 : tail;
                end
            end
            S_RAW2: begin
                if (free) begin
                    load      = 1'b1;
                    load_byte = op_b1_d;
                    state_d   = tail;
                end
            end
            S_PAD: begin
                if (cnt_eff >= ChunkC) begin
                    state_d = S_IN;
                end else if (free) begin
                    load      = 1'b1;
                    load_byte = PAD_BYTE;
                    state_d   = (cnt_p1 == ChunkC) ? S_IN : S_PAD;
                end
            end
            default: state_d = S_IN;
        endcase

        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        if (load) begin
            cnt_d       = cnt_p1;
            out_valid_d = 1'b1;
            out_byte_d  = load_byte;
            out_last_d  = (cnt_p1 == ChunkC);
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        pix_ready_d = (state_d == S_IN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IN;
            pix_ready_q <= 1'b0;
            prev_q      <= '0;
            run_q       <= 6'd0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            run_byte_q  <= 8'h00;
            op_b0_q     <= 8'h00;
            op_b1_q     <= 8'h00;
            op_raw_q    <= 1'b0;
            op_has_q    <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_ready_q <= pix_ready_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            run_byte_q  <= run_byte_d;
            op_b0_q     <= op_b0_d;
            op_b1_q     <= op_b1_d;
            op_raw_q    <= op_raw_d;
            op_has_q    <= op_has_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
        end
    end

    assign io.pix_ready = pix_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_byte  = out_byte_q;
    assign io.out_last  = out_last_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_qoi_rgb444_encoder.sv
// Directed bench for qoi_rgb444_encoder: two-pixel chunk table plus run, budget,
// stall, reset and abandoned-chunk sequences; expected bytes are hand-computed.
module tb_qoi_rgb444_encoder;
    import qoi_rgb444_pkg::*;

    localparam int unsigned Chunk = 320;
    localparam logic [7:0]  Pad   = 8'hC1;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed { logic last; logic [7:0] b; } cap_t;
    typedef struct { rgb444_t a; rgb444_t b; logic [0:3][7:0] e; int n; } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    rgb444_t [PAL_SIZE-1:0] palette;
    logic                   overflow;
    int                     comps = 0;
    int                     errs = 0;
    cap_t                   cap [$];
    vec_t                   vecs [8];

    qoi_rgb444_encoder_if bus ();

    qoi_rgb444_encoder #(
        .CHUNK_BYTES (Chunk),
        .PAD_BYTE    (Pad)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (bus),
        .palette  (palette),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Handshake completes at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) cap.push_back({bus.out_last, bus.out_byte});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        comps++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic send_pix(input rgb444_t c, input logic f, input logic l);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_rgb   = c;
        bus.pix_first = f;
        bus.pix_last  = l;
        @(negedge clk);
        while (!bus.pix_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) begin
            comps++;
            errs++;
            $display("FAIL pix_ready timeout: got 0 want 1");
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_first = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (cap.size() < n && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (cap.size() < n) begin
            comps++;
            errs++;
            $display("FAIL byte timeout: got %0d bytes want %0d", cap.size(), n);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name, input byte_q_t want);
        int bad = -1;
        int nlast = 0;
        int lastpos = -1;
        comps++;
        if (cap.size() != want.size()) begin
            errs++;
            $display("FAIL %s count: got %0d want %0d", name, cap.size(), want.size());
        end
        for (int k = 0; k < cap.size() && k < want.size(); k++) begin
            if (bad < 0 && cap[k].b !== want[k]) bad = k;
        end
        comps++;
        if (bad >= 0) begin
            errs++;
            $display("FAIL %s byte[%0d]: got %02h want %02h", name, bad, cap[bad].b, want[bad]);
        end
        for (int k = 0; k < cap.size(); k++) begin
            if (cap[k].last) begin
                nlast++;
                lastpos = k;
            end
        end
        comps++;
        if (nlast != 1 || lastpos != want.size() - 1) begin
            errs++;
            $display("FAIL %s out_last: got %0d marks, last at %0d want 1 mark at %0d",
                     name, nlast, lastpos, want.size() - 1);
        end
        cap.delete();
    endtask

    initial begin
        byte_q_t want;

        bus.pix_valid = 1'b0;
        bus.pix_rgb   = '0;
        bus.pix_first = 1'b0;
        bus.pix_last  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < PAL_SIZE; i++) palette[i] = 12'hFFF;
        palette[5]  = 12'hABC;
        palette[40] = 12'hABC;

        vecs[0] = '{12'h123, 12'h234, {8'h81, 8'h23, 8'h55, 8'h00}, 3};
        vecs[1] = '{12'h123, 12'h012, {8'h81, 8'h23, 8'h7F, 8'h00}, 3};
        vecs[2] = '{12'h000, 12'h9F0, {8'hC1, 8'h89, 8'hF0, 8'h00}, 3};
        vecs[3] = '{12'h001, 12'h000, {8'h69, 8'h6B, 8'h00, 8'h00}, 2};
        vecs[4] = '{12'hF00, 12'hF00, {8'h7A, 8'hC1, 8'h00, 8'h00}, 2};
`ifdef QOI_ENC_INDEX_EN
        vecs[5] = '{12'hABC, 12'hABC, {8'h05, 8'hC1, 8'h00, 8'h00}, 2};
`else
        vecs[5] = '{12'hABC, 12'hABC, {8'h8A, 8'hBC, 8'hC1, 8'h00}, 3};
`endif
        vecs[6] = '{12'h222, 12'h000, {8'h40, 8'h80, 8'h00, 8'h00}, 3};
        vecs[7] = '{12'h000, 12'h000, {8'hC2, 8'h00, 8'h00, 8'h00}, 1};

        #12;
        chk("reset pix_ready", bus.pix_ready, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_byte", bus.out_byte, 0);
        chk("reset out_last", bus.out_last, 0);
        chk("reset overflow", overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("pix_ready after reset", bus.pix_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send_pix(vecs[i].a, 1'b1, 1'b0);
            send_pix(vecs[i].b, 1'b0, 1'b1);
            wait_bytes(Chunk);
            want.delete();
            for (int k = 0; k < vecs[i].n; k++) want.push_back(vecs[i].e[k]);
            while (want.size() < Chunk) want.push_back(Pad);
            check_stream($sformatf("vec%0d", i), want);
            chk($sformatf("vec%0d overflow", i), overflow, 0);
        end

        // Run of three then a palette colour.
        send_pix(12'h000, 1'b1, 1'b0);
        send_pix(12'h000, 1'b0, 1'b0);
        send_pix(12'h000, 1'b0, 1'b0);
        send_pix(12'hABC, 1'b0, 1'b1);
        wait_bytes(Chunk);
`ifdef QOI_ENC_INDEX_EN
        want = '{8'hC3, 8'h05};
`else
        want = '{8'hC3, 8'h8A, 8'hBC};
`endif
        while (want.size() < Chunk) want.push_back(Pad);
        check_stream("run3_index", want);

        // 70 identical pixels: RAW, RUN(63), RUN(6).
        for (int k = 1; k <= 70; k++) send_pix(12'h555, k == 1, k == 70);
        wait_bytes(Chunk);
        want = '{8'h85, 8'h55, 8'hFF, 8'hC6};
        while (want.size() < Chunk) want.push_back(Pad);
        check_stream("run70", want);

        // Budget: 319 bytes used, then every RAW is dropped whole.
        send_pix(12'h000, 1'b1, 1'b0);
        for (int k = 2; k <= 170; k++) send_pix((k % 2 == 0) ? 12'h888 : 12'h000, 1'b0, k == 170);
        wait_bytes(Chunk);
        want = '{8'hC1, 8'h88, 8'h88};
        for (int k = 3; k <= 160; k++) begin
            if (k % 2 == 1) begin
                want.push_back(8'h80);
                want.push_back(8'h00);
            end else begin
                want.push_back(8'h88);
                want.push_back(8'h88);
            end
        end
        want.push_back(Pad);
        check_stream("budget", want);
        chk("budget overflow set", overflow, 1);
        send_pix(12'h123, 1'b1, 1'b0);
        @(negedge clk);
        chk("overflow cleared by first", overflow, 0);
        send_pix(12'h234, 1'b0, 1'b1);
        wait_bytes(Chunk);
        want = '{8'h81, 8'h23, 8'h55};
        while (want.size() < Chunk) want.push_back(Pad);
        check_stream("after_budget", want);

        // Output stall in the middle of a RAW pair.
        bus.out_ready = 1'b0;
        send_pix(12'h9F0, 1'b1, 1'b0);
        @(negedge clk);
        chk("latency out_valid/byte", {bus.out_valid, bus.out_byte}, {1'b1, 8'h89});
        repeat (5) begin
            @(negedge clk);
            chk("stall hold", {bus.out_valid, bus.out_byte}, {1'b1, 8'h89});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_pix(12'h9F0, 1'b0, 1'b1);
        wait_bytes(Chunk);
        want = '{8'h89, 8'hF0, 8'hC1};
        while (want.size() < Chunk) want.push_back(Pad);
        check_stream("stall", want);

        // Reset in mid-chunk with a byte in flight.
        bus.out_ready = 1'b0;
        send_pix(12'h123, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset out_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", bus.out_valid, 0);
        chk("mid reset pix_ready", bus.pix_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap.delete();
        bus.out_ready = 1'b1;
        send_pix(12'h000, 1'b0, 1'b0);
        send_pix(12'h9F0, 1'b0, 1'b1);
        wait_bytes(Chunk);
        want = '{8'hC1, 8'h89, 8'hF0};
        while (want.size() < Chunk) want.push_back(Pad);
        check_stream("post_reset", want);

        // New chunk opened while the previous one is unfinished with a run pending.
        send_pix(12'h555, 1'b1, 1'b0);
        send_pix(12'h555, 1'b0, 1'b0);
        send_pix(12'h000, 1'b1, 1'b0);
        send_pix(12'h9F0, 1'b0, 1'b1);
        wait_bytes(Chunk + 2);
        want = '{8'h85, 8'h55, 8'hC1, 8'h89, 8'hF0};
        while (want.size() < Chunk + 2) want.push_back(Pad);
        check_stream("abandon", want);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
